// File: rtl/pipe_chain.sv
// pipe_chain: parametrised valid/ready register chain with bubble collapse and single-cycle flush.
// Define PIPE_CHAIN_OCC_EN to add the o_occupancy live-entry counter.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
`ifdef PIPE_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy
`endif
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // A stage may advance if it is empty or everything downstream of it moves.
  always_comb begin
    logic carry;
    w_adv = '0;
    carry = ~r_vld[DEPTH-1] | i_out_ready;
    w_adv[DEPTH-1] = carry;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      carry    = ~r_vld[k] | carry;
      w_adv[k] = carry;
    end
  end

  assign o_in_ready  = w_adv[0] & ~i_flush & ~i_reset;
  assign o_out_valid = r_vld[DEPTH-1] & ~i_flush & ~i_reset;
  assign o_out_data  = r_data[DEPTH-1];
  assign w_in_xfer   = i_in_valid & o_in_ready;
  assign w_out_xfer  = o_out_valid & i_out_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) r_vld[0] <= w_in_xfer;
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k]) r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Payload registers carry no reset; bubbles never overwrite them.
  always_ff @(posedge i_clock) begin
    if (w_adv[0] && w_in_xfer) r_data[0] <= i_in_data;
    for (int k = 1; k < DEPTH; k++) begin
      if (w_adv[k] && r_vld[k-1]) r_data[k] <= r_data[k-1];
    end
  end

`ifdef PIPE_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_occ <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain (WIDTH=32, DEPTH=4): stimulus queues expected words, a monitor pops them.
module tb_pipe_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_CHAIN_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data)
`ifdef PIPE_CHAIN_OCC_EN
    ,
    .o_occupancy(occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stalls = 0;
  logic [WIDTH-1:0] exp_q [$];
  int out_cyc_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an output transfer happens at the next rising edge whenever valid & ready.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", out_data, 32'hxxxxxxxx);
      end else begin
        chk("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      tick();
    end
    if (in_ready) begin
      exp_q.push_back(d);
      tick();
    end else begin
      chk("push_timeout", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      n++;
      tick();
    end
    tick();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic lat_check(input string name, input logic [WIDTH-1:0] d);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, out_data, d);
    tick();
    chk({name, "_one_cycle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a producer already offering data.
    #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1111_1111; out_ready = 1'b1;
    tick();
    chk("rst_in_ready_c1", 32'(in_ready), 32'd0);
    chk("rst_out_valid_c1", 32'(out_valid), 32'd0);
    tick();
    chk("rst_in_ready_c2", 32'(in_ready), 32'd0);
    chk("rst_out_valid_c2", 32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    chk("rst_release_out_valid", 32'(out_valid), 32'd0);
`ifdef PIPE_CHAIN_OCC_EN
    chk("rst_occ", 32'(occ), 32'd0);
`endif
    tick();

    // Minimum latency of DEPTH cycles, single-cycle output.
    lat_check("latency", 32'hA5A5_A5A5);

    // Back-to-back stream of 0..99.
    out_ready = 1'b1;
    stalls = 0;
    out_cyc_q.delete();
    for (int i = 0; i < 100; i++) push(32'(i));
    chk("stream_no_stall", stalls, 0);
    drain("stream_drain");
    chk("stream_count", out_cyc_q.size(), 100);
    if (out_cyc_q.size() >= 100) chk("stream_no_gap", out_cyc_q[99] - out_cyc_q[0], 99);

    // Backpressure: four words fill the chain, the fifth stalls.
    out_ready = 1'b0;
    stalls = 0;
    for (int i = 0; i < 4; i++) push(32'(i));
    chk("bp_fill_no_stall", stalls, 0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_data", out_data, 32'd0);
`ifdef PIPE_CHAIN_OCC_EN
    chk("bp_occ_peak", 32'(occ), 32'd4);
`endif
    in_valid = 1'b1; in_data = 32'd4;
    tick();
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_head", out_data, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_passthrough", 32'(in_ready), 32'd1);
    push(32'd4);
    push(32'd5);
    drain("bp_drain");

    // Bubble collapse: gapped words pack up behind a stalled output.
    out_ready = 1'b0;
    tick();
    push(32'h100);
    tick();
    tick();
    push(32'h200);
    tick();
    tick();
    chk("bub_in_ready", 32'(in_ready), 32'd1);
    chk("bub_head", out_data, 32'h100);
`ifdef PIPE_CHAIN_OCC_EN
    chk("bub_occ", 32'(occ), 32'd2);
`endif
    stalls = 0;
    push(32'h300);
    push(32'h400);
    chk("bub_pack_no_stall", stalls, 0);
    chk("bub_full_in_ready", 32'(in_ready), 32'd0);
    drain("bub_drain");

    // Flush with three entries in flight and a word offered in the flush cycle.
    out_ready = 1'b0;
    push(32'h301);
    push(32'h302);
    push(32'h303);
    tick();
    chk("fl_pre_out_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    #1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_after_out_valid", 32'(out_valid), 32'd0);
    chk("fl_after_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_CHAIN_OCC_EN
    chk("fl_occ", 32'(occ), 32'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      chk("fl_stays_empty", 32'(out_valid), 32'd0);
      tick();
    end
    lat_check("fl_relatency", 32'h0000_0400);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
